// File: rtl/elev_call_panel.sv
// elev_call_panel: debounces raw car/hall buttons into pending calls for the elevator
// controller and retires them when the door opens. Define CALL_CANCEL_EN to let a re-press cancel a car call.
module elev_call_panel #(
  parameter int NUM_FLOORS = 10,
  parameter int DEB_CYCLES = 4,
  localparam int FLOOR_W = $clog2(NUM_FLOORS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] raw_inside,
  input  logic [NUM_FLOORS-2:0] raw_up,
  input  logic [NUM_FLOORS-2:0] raw_down,
  input  logic                  up_signal,
  input  logic                  down_signal,
  input  logic                  open_door,
  input  logic [FLOOR_W-1:0]    floor,
  output logic [NUM_FLOORS-1:0] buttons_inside,
  output logic [NUM_FLOORS-2:0] buttons_outside_up,
  output logic [NUM_FLOORS-2:0] buttons_outside_down,
  output logic                  any_call,
  output logic                  proto_err
);

  // Flat button vector: inside[f] at f, up[f] at UP_BASE+f, down[f] at DN_BASE+f-1.
  localparam int NB      = 3*NUM_FLOORS - 2;
  localparam int UP_BASE = NUM_FLOORS;
  localparam int DN_BASE = 2*NUM_FLOORS - 1;
  localparam int CNT_W   = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0]   DEB_MAX   = CNT_W'(DEB_CYCLES);
  localparam logic [CNT_W-1:0]   DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_e;
  typedef enum logic {DOOR_CLOSED, DOOR_OPEN} door_e;

  logic [NB-1:0]    rawAll;
  logic [NB-1:0]    sync1_q, sync2_q;
  logic [NB-1:0]    calls_q, calls_d;
  logic [NB-1:0]    press, servedMask, clearMask, setMask;
  logic [CNT_W-1:0] cnt_q [NB];
  logic [CNT_W-1:0] cnt_d [NB];
  dir_e             dir_q, dir_d;
  door_e            door_q, door_d;
  logic             anyCall_q;
  logic             protoErr_q, protoErr_d;
  logic             floorValid, serve;

  assign rawAll     = {raw_down, raw_up, raw_inside};
  assign floorValid = (floor <= TOP_FLOOR);
  assign serve      = (door_q == DOOR_CLOSED) && open_door;

  // The press pulse fires on the cycle the counter saturates, so holding never repeats.
  always_comb begin
    press = '0;
    for (int i = 0; i < NB; i++) begin
      cnt_d[i] = cnt_q[i];
      if (!sync2_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] < DEB_MAX) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
        press[i] = (cnt_q[i] == DEB_LAST);
      end
    end
  end

  // Terminal floors retire the only hall call that exists there, whatever the direction.
  always_comb begin
    servedMask = '0;
    if (floorValid) begin
      for (int f = 0; f < NUM_FLOORS; f++)
        if (floor == FLOOR_W'(f)) servedMask[f] = 1'b1;
      for (int f = 0; f < NUM_FLOORS-1; f++)
        if (floor == FLOOR_W'(f))
          servedMask[UP_BASE+f] = (dir_q != DIR_DOWN) || (f == 0);
      for (int f = 1; f < NUM_FLOORS; f++)
        if (floor == FLOOR_W'(f))
          servedMask[DN_BASE+f-1] = (dir_q != DIR_UP) || (f == NUM_FLOORS-1);
    end
  end

  always_comb begin
    clearMask = serve ? servedMask : '0;
    setMask   = press & ~((door_q == DOOR_OPEN) ? servedMask : '0);
    calls_d   = (calls_q | setMask) & ~clearMask;
`ifdef CALL_CANCEL_EN
    calls_d[NUM_FLOORS-1:0] = (calls_q[NUM_FLOORS-1:0] ^ setMask[NUM_FLOORS-1:0])
                              & ~clearMask[NUM_FLOORS-1:0];
`endif
    dir_d = dir_q;
    if (up_signal)        dir_d = DIR_UP;
    else if (down_signal) dir_d = DIR_DOWN;
    door_d     = open_door ? DOOR_OPEN : DOOR_CLOSED;
    protoErr_d = protoErr_q | (up_signal & down_signal) | ~floorValid;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      calls_q    <= '0;
      for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
      dir_q      <= DIR_NONE;
      door_q     <= DOOR_CLOSED;
      anyCall_q  <= 1'b0;
      protoErr_q <= 1'b0;
    end else begin
      sync1_q    <= rawAll;
      sync2_q    <= sync1_q;
      for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
      calls_q    <= calls_d;
      dir_q      <= dir_d;
      door_q     <= door_d;
      anyCall_q  <= |calls_d;
      protoErr_q <= protoErr_d;
    end
  end

  assign buttons_inside       = calls_q[NUM_FLOORS-1:0];
  assign buttons_outside_up   = calls_q[DN_BASE-1:UP_BASE];
  assign buttons_outside_down = calls_q[NB-1:DN_BASE];
  assign any_call             = anyCall_q;
  assign proto_err            = protoErr_q;

endmodule
